// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU operand loader: word geometry, loader state and status.
// Exponent geometry matches the operand format: 1 sign bit, EXP_W exponent bits, MAN_W mantissa bits.
package fpu_pkg;

  localparam int WORD_W      = 32;
  localparam int EXP_W       = 10;
  localparam int MAN_W       = 21;
  localparam int BIAS        = 511;
  localparam int FRAME_BYTES = 8;

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } loader_state_e;

  // Observable loader status; the top drives its handshake outputs from this.
  typedef struct packed {
    loader_state_e state;
    logic          ready;
    logic          start;
  } status_t;

  function automatic logic exp_is_zero(input logic [WORD_W-1:0] w);
    return (w[MAN_W +: EXP_W] == '0);
  endfunction

endpackage

// File: rtl/fpu_op_flush.sv
// Combinational zero-exponent flush for one operand; active only when FPU_LOADER_FLUSH_EN is defined,
// otherwise a pass-through with flushed_o tied low.
module fpu_op_flush
  import fpu_pkg::*;
(
  input  logic [WORD_W-1:0] op_i,
  output logic [WORD_W-1:0] op_o,
  output logic              flushed_o
);

`ifdef FPU_LOADER_FLUSH_EN
  always_comb begin
    flushed_o = exp_is_zero(op_i);
    op_o      = flushed_o ? '0 : op_i;
  end
`else
  assign op_o      = op_i;
  assign flushed_o = 1'b0;
`endif

endmodule

// File: rtl/fpu_op_loader.sv
// Assembles 8-byte frames (A then B, MSB first) and presents them to the FPU for a fixed hold window.
// Optional zero-exponent flush is enabled by defining FPU_LOADER_FLUSH_EN.
module fpu_op_loader
  import fpu_pkg::*;
#(
  parameter int HOLD_CYCLES    = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock_100Khz,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] Op_A_out,
  output logic [WORD_W-1:0] Op_B_out,
  output logic              op_start,
  output logic              op_busy,
  output logic              frame_err,
  output logic              flush_out
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);
  localparam int SHAD_W = 8 * (FRAME_BYTES - 1);

  loader_state_e     state_q, state_d;
  status_t           status;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [SHAD_W-1:0] shadow_q, shadow_d;
  logic [WORD_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic              flush_q, flush_d;
  logic              frame_err_q, frame_err_d;

  logic                  accept, frame_full, hold_done, timeout;
  logic [2*WORD_W-1:0]   frame_word;
  logic [WORD_W-1:0]     op_a_fl, op_b_fl;
  logic                  a_flushed, b_flushed;

  // The last byte bypasses the shadow so the pair is presented the very next cycle.
  assign frame_word = {shadow_q, in_data};
  assign accept     = in_valid && status.ready;
  assign frame_full = accept && (byte_cnt_q == 3'(FRAME_BYTES - 1));
  assign hold_done  = (state_q == HOLD) && (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
  assign timeout    = (state_q == LOAD) && (byte_cnt_q != '0) && !accept &&
                      (idle_cnt_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  fpu_op_flush u_flush_a (
    .op_i      (frame_word[2*WORD_W-1:WORD_W]),
    .op_o      (op_a_fl),
    .flushed_o (a_flushed)
  );

  fpu_op_flush u_flush_b (
    .op_i      (frame_word[WORD_W-1:0]),
    .op_o      (op_b_fl),
    .flushed_o (b_flushed)
  );

  always_ff @(posedge clock_100Khz) begin
    if (reset) state_q <= LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (frame_full) state_d = HOLD;
      HOLD:    if (hold_done)  state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // Handshake: in_valid/in_ready transfer a byte on any cycle where both are high; in_ready never
  // depends on in_valid and is forced low while reset is asserted.
  always_comb begin
    status.state = state_q;
    status.ready = (state_q == LOAD) && !reset;
    status.start = (state_q == HOLD) && (hold_cnt_q == '0);
  end

  assign in_ready  = status.ready;
  assign op_start  = status.start;
  assign op_busy   = (status.state == HOLD);
  assign Op_A_out  = op_a_q;
  assign Op_B_out  = op_b_q;
  assign flush_out = flush_q;
  assign frame_err = frame_err_q;

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    hold_cnt_d  = '0;
    shadow_d    = shadow_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    flush_d     = flush_q;
    frame_err_d = 1'b0;

    if ((state_q == HOLD) && !hold_done) hold_cnt_d = hold_cnt_q + 1'b1;

    if (accept) begin
      idle_cnt_d = '0;
      if (frame_full) begin
        byte_cnt_d = '0;
        shadow_d   = '0;
        op_a_d     = op_a_fl;
        op_b_d     = op_b_fl;
        flush_d    = a_flushed || b_flushed;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        shadow_d   = {shadow_q[SHAD_W-9:0], in_data};
      end
    end else if ((state_q == LOAD) && (byte_cnt_q != '0)) begin
      if (timeout) begin
        byte_cnt_d  = '0;
        idle_cnt_d  = '0;
        shadow_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end
  end

  always_ff @(posedge clock_100Khz) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      shadow_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      flush_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      shadow_q    <= shadow_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      flush_q     <= flush_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fpu_op_loader.sv
// Directed, table-driven bench for fpu_op_loader: frame assembly, hold window, timeout, flush, reset abort.
module tb_fpu_op_loader;

  localparam int HOLD = 10;
  localparam int TMO  = 64;
`ifdef FPU_LOADER_FLUSH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Op_A_out;
  logic [31:0] Op_B_out;
  logic        op_start;
  logic        op_busy;
  logic        frame_err;
  logic        flush_out;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] cur_a = '0;
  logic [31:0] cur_b = '0;
  logic        cur_f = 1'b0;

  typedef struct {
    logic [63:0] frame;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_f;
    logic        hold_valid;
    int          gap_len;
  } vec_t;

  vec_t vecs[6];

  fpu_op_loader #(.HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_100Khz (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .Op_A_out     (Op_A_out),
    .Op_B_out     (Op_B_out),
    .op_start     (op_start),
    .op_busy      (op_busy),
    .frame_err    (frame_err),
    .flush_out    (flush_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bytes(input logic [63:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = f[63-8*i -: 8];
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Sends one frame, checking outputs stay put while partial, then the full hold window.
  task automatic run_frame(input vec_t v, input logic [7:0] next_b0);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = v.frame[63-8*i -: 8];
      check("in_ready_load", in_ready, 1);
      check("frame_err_idle", frame_err, 0);
      if (i > 0) begin
        check("partial_a", Op_A_out, cur_a);
        check("partial_b", Op_B_out, cur_b);
        check("partial_start", op_start, 0);
      end
      tick();
      if (i == 2 && v.gap_len > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < v.gap_len; g++) begin
          check("gap_err", frame_err, 0);
          tick();
        end
      end
    end
    in_valid = v.hold_valid;
    in_data  = next_b0;
    check("start_pulse", op_start, 1);
    check("busy_first", op_busy, 1);
    check("ready_first", in_ready, 0);
    check("op_a", Op_A_out, v.exp_a);
    check("op_b", Op_B_out, v.exp_b);
    check("flush", flush_out, v.exp_f);
    for (int k = 1; k < HOLD; k++) begin
      tick();
      check("busy_hold", op_busy, 1);
      check("start_once", op_start, 0);
      check("ready_hold", in_ready, 0);
      check("hold_a_stable", Op_A_out, v.exp_a);
    end
    tick();
    check("busy_end", op_busy, 0);
    check("ready_end", in_ready, 1);
    check("start_end", op_start, 0);
    cur_a = v.exp_a;
    cur_b = v.exp_b;
    cur_f = v.exp_f;
  endtask

  initial begin
    vec_t tv;
    vecs[0] = '{64'h40000000_3FE00000, 32'h40000000, 32'h3FE00000, 1'b0, 1'b1, 0};
    vecs[1] = '{64'h3F800000_C0000000, 32'h3F800000, 32'hC0000000, 1'b0, 1'b0, TMO-1};
    vecs[2] = '{64'h00100000_3FE00000, FL ? 32'h0 : 32'h00100000, 32'h3FE00000, FL, 1'b1, 0};
    vecs[3] = '{64'hC0000000_80000000, 32'hC0000000, FL ? 32'h0 : 32'h80000000, FL, 1'b0, 0};
    vecs[4] = '{64'h7FFFFFFF_00200000, 32'h7FFFFFFF, 32'h00200000, 1'b0, 1'b0, 0};
    vecs[5] = '{64'h12345678_9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 0};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_busy", op_busy, 0);
    check("rst_start", op_start, 0);
    check("rst_a", Op_A_out, 32'h0);
    check("rst_b", Op_B_out, 32'h0);
    check("rst_flush", flush_out, 0);
    check("rst_err", frame_err, 0);
    check("rst_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 1);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i], (i < 5) ? vecs[i+1].frame[63:56] : 8'h00);
    end

    // Three bytes then silence: one frame_err pulse, outputs untouched.
    send_bytes(64'h11223300_00000000, 3);
    for (int j = 1; j <= TMO; j++) begin
      check("tmo_no_err_yet", frame_err, 0);
      tick();
    end
    check("tmo_err_pulse", frame_err, 1);
    check("tmo_a_kept", Op_A_out, cur_a);
    check("tmo_b_kept", Op_B_out, cur_b);
    tick();
    check("tmo_err_single", frame_err, 0);
    tv = '{64'h40200000_BFE80000, 32'h40200000, 32'hBFE80000, 1'b0, 1'b0, 0};
    run_frame(tv, 8'h00);

    // Reset in the 4th hold cycle aborts the window.
    send_bytes(64'h40000000_3FE00000, 8);
    check("rh_start", op_start, 1);
    repeat (3) tick();
    check("rh_busy4", op_busy, 1);
    reset = 1'b1;
    tick();
    check("rh_busy", op_busy, 0);
    check("rh_a", Op_A_out, 32'h0);
    check("rh_b", Op_B_out, 32'h0);
    check("rh_flush", flush_out, 0);
    check("rh_ready_in_rst", in_ready, 0);
    reset = 1'b0;
    #1;
    check("rh_ready", in_ready, 1);
    cur_a = '0;
    cur_b = '0;
    cur_f = 1'b0;

    // Reset mid-frame discards the partial bytes.
    send_bytes(64'hAABBCCDD_00000000, 4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    run_frame(vecs[0], 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
